// File: rtl/radix4_mult_arbiter.sv
// Round-robin arbiter that shares one radix4_mult instance among NUM_REQ requesters.
// Defining RADIX4_ARB_STATS_EN adds the stat_issued / stat_stall counter outputs.
module radix4_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MULT_LAT  = 2,
  parameter int PIPELINED = 1
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [63:0]            rsp_data,
  output logic [31:0]            mult_a,
  output logic [31:0]            mult_b,
  input  logic [63:0]            mult_c,
  output logic                   dbg_state
`ifdef RADIX4_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = MULT_LAT + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            issue_ok;
  logic            hs;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [DEPTH-1:0] trk_v;
  logic [ID_W-1:0]  trk_id [DEPTH];

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[wrap_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_id    = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign issue_ok = (PIPELINED != 0) || (state_q == ST_IDLE);

  // Handshake: a request transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both 1; valid may drop at any time without a transfer,
  // and operands are only sampled on the transfer edge.
  always_comb begin
    req_ready = '0;
    if (rst_n && issue_ok && win_found) req_ready[win_id] = 1'b1;
  end

  assign hs = |(req_valid & req_ready);

  always_comb begin
    sel_a = req_a[int'(win_id)*32 +: 32];
    sel_b = req_b[int'(win_id)*32 +: 32];
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      mult_a <= '0;
      mult_b <= '0;
      rr_ptr <= '0;
    end else if (hs) begin
      mult_a <= sel_a;
      mult_b <= sel_b;
      rr_ptr <= wrap_idx(win_id, 1);
    end
  end

  // Tag tracker: stage MULT_LAT lines up with the product settling on mult_c.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      trk_v <= '0;
      for (int i = 0; i < DEPTH; i++) trk_id[i] <= '0;
    end else begin
      trk_v     <= {trk_v[DEPTH-2:0], hs};
      trk_id[0] <= win_id;
      for (int i = 1; i < DEPTH; i++) trk_id[i] <= trk_id[i-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (trk_v[MULT_LAT]) rsp_valid[trk_id[MULT_LAT]] = 1'b1;
  end

  assign rsp_data = mult_c;

  always_ff @(posedge CLK) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Only the non-pipelined build ever leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs && (PIPELINED == 0)) state_d = ST_WAIT;
      ST_WAIT: if (|rsp_valid)             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

`ifdef RADIX4_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (hs)                      stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !hs)     stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
